// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: shared state encoding and helpers for the async FIFO write side
package async_fifo_pkg;
    typedef enum logic [1:0] {IDLE, XFER, PAD} state_t;
    localparam int RST_HOLD_CYCLES = 7;
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: first set request at or above ptr, wrapping around
module rr_priority_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);
    logic [IW-1:0] j;
    // scan offsets from far to near so the nearest set bit at or above ptr wins
    always_comb begin
        idx = '0;
        j = '0;
        found = |req;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) idx = j;
        end
    end
endmodule

// File: rtl/async_fifo_wr_arbiter.sv
// async_fifo_wr_arbiter: word-atomic round-robin write arbiter for a concatenating async FIFO
module async_fifo_wr_arbiter
    import async_fifo_pkg::*;
#(
    parameter int         NUM_REQ          = 4,
    parameter int         WR_WIDTH_BYTES   = 1,
    parameter int         WIDTH_RATIO_LOG2 = 2,
    parameter int         MAX_BURST_WORDS  = 4,
    parameter logic [7:0] PAD_BYTE         = 8'h00,
    localparam int        W                = 8 * WR_WIDTH_BYTES,
    localparam int        GW               = clog2(NUM_REQ)
) (
    input  logic                 rst,
    input  logic                 wr_clk,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ-1:0]   req_last,
    input  logic [NUM_REQ*W-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic                 fifo_full,
    output logic                 fifo_wr_en,
    output logic [W-1:0]         fifo_wr_data,
    output logic [GW-1:0]        grant_id,
    output logic                 busy,
    output logic [15:0]          pad_beats
);
    localparam int BW = WIDTH_RATIO_LOG2 > 0 ? WIDTH_RATIO_LOG2 : 1;
    localparam int CW = clog2(MAX_BURST_WORDS + 1);
    localparam logic [BW-1:0] BEAT_MAX = BW'((1 << WIDTH_RATIO_LOG2) - 1);
    localparam logic [CW-1:0] LAST_WORD = CW'(MAX_BURST_WORDS - 1);

    state_t state, state_nxt;
    logic [2:0] hold_cnt;
    logic hold, beat, pad, wrap, found;
    logic [BW-1:0] beat_cnt;
    logic [CW-1:0] word_cnt;
    logic [GW-1:0] rr_ptr, pick;
    logic [W-1:0] sel_data;

    assign hold = hold_cnt != 3'd0;
    assign busy = state != IDLE;

    rr_priority_pick #(.N(NUM_REQ), .IW(GW)) u_pick (
        .req(req_valid),
        .ptr(rr_ptr),
        .idx(pick),
        .found(found)
    );

    // granted requester's beat
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) if (GW'(i) == grant_id) sel_data = req_data[i*W +: W];
    end

    // zero-latency handshake and write-port mux
    always_comb begin
        beat = state == XFER && req_valid[grant_id] && !fifo_full;
        pad = state == PAD && !fifo_full;
        wrap = beat_cnt == BEAT_MAX;
        req_ready = (state == XFER && !fifo_full) ? NUM_REQ'(1) << grant_id : '0;
        fifo_wr_en = beat || pad;
        fifo_wr_data = state == PAD ? {WR_WIDTH_BYTES{PAD_BYTE}} : sel_data;
    end

    // next state: grant from IDLE, end-of-message and burst limit in XFER, fill to boundary in PAD
    always_comb begin
        state_nxt = state;
        if (state == IDLE && found) state_nxt = XFER;
        if (beat && req_last[grant_id]) state_nxt = wrap ? IDLE : PAD;
        else if (beat && wrap && word_cnt == LAST_WORD) state_nxt = IDLE;
        if (pad && wrap) state_nxt = IDLE;
        if (hold) state_nxt = IDLE;
    end

    // keep grants off until the FIFO's own write-reset stretch has expired
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) hold_cnt <= 3'(RST_HOLD_CYCLES);
        else if (hold) hold_cnt <= hold_cnt - 3'd1;
    end

    // state, grant, word-position counters and pad statistics
    always_ff @(posedge wr_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            grant_id <= '0;
            rr_ptr <= '0;
            beat_cnt <= '0;
            word_cnt <= '0;
            pad_beats <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && state_nxt == XFER) grant_id <= pick;
            if (state != IDLE && state_nxt == IDLE) begin
                rr_ptr <= grant_id == GW'(NUM_REQ - 1) ? '0 : grant_id + GW'(1);
                beat_cnt <= '0;
                word_cnt <= '0;
            end else if (beat || pad) begin
                beat_cnt <= wrap ? '0 : beat_cnt + BW'(1);
                if (beat && wrap) word_cnt <= word_cnt + CW'(1);
            end
            if (pad && pad_beats != 16'hFFFF) pad_beats <= pad_beats + 16'd1;
        end
    end
endmodule
